// File: rtl/pwm_div_sched.sv
// pwm_div_sched: clock-enable prescaler plus single-channel PWM sequencer.
// New configs are shadowed while running and applied only at a period boundary.
module pwm_div_sched #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             tick,
    output logic             pwm_out,
    output logic             period_end,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DIV_W-1:0] pre_q;
    logic [CNT_W-1:0] cnt_q;

    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] duty_q;

    logic [DIV_W-1:0] div_sh;
    logic [CNT_W-1:0] per_sh;
    logic [CNT_W-1:0] duty_sh;

    logic has_cfg_q;
    logic pending_q;
    logic err_q;

    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_last;
    logic [CNT_W-1:0] per_last;
    logic             is_idle;
    logic             xfer;
    logic             bad_cfg;
    logic             good_cfg;
    logic             start_err;

    // Datapath decode: prescaler compare, period compare and PWM level.
    always_comb begin
        is_idle    = (state_q == IDLE);
        busy       = ~is_idle;
        div_act    = (div_q == '0) ? DIV_W'(1) : div_q;
        div_last   = div_act - DIV_W'(1);
        per_last   = per_q - CNT_W'(1);
        tick       = busy & (pre_q == div_last);
        period_end = tick & (cnt_q == per_last);
        pwm_out    = busy & (cnt_q < duty_q);
        cfg_ready  = ~pending_q;
        cfg_err    = err_q;
        xfer       = cfg_valid & cfg_ready;
        bad_cfg    = xfer & (cfg_period == '0);
        good_cfg   = xfer & ~bad_cfg;
    end

    // Next-state logic; start only counts in IDLE, stop only in RUN.
    always_comb begin
        state_d   = state_q;
        start_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (has_cfg_q) begin
                        state_d = RUN;
                    end else begin
                        start_err = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (period_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Error pulse, registered so it appears the cycle after the cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= start_err | bad_cfg;
        end
    end

    // Prescaler and period counters; both wrap together at period_end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (is_idle) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
            if (period_end) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            pre_q <= pre_q + DIV_W'(1);
        end
    end

    // Config capture: direct load when idle, shadow load while running.
    // A shadow left pending on the way into IDLE is flushed there so
    // cfg_ready cannot stay low with no boundary left to release it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            per_q     <= '0;
            duty_q    <= '0;
            div_sh    <= '0;
            per_sh    <= '0;
            duty_sh   <= '0;
            has_cfg_q <= 1'b0;
            pending_q <= 1'b0;
        end else if (good_cfg && is_idle) begin
            div_q     <= cfg_div;
            per_q     <= cfg_period;
            duty_q    <= cfg_duty;
            has_cfg_q <= 1'b1;
        end else if (good_cfg) begin
            div_sh    <= cfg_div;
            per_sh    <= cfg_period;
            duty_sh   <= cfg_duty;
            pending_q <= 1'b1;
        end else if (pending_q && (period_end || is_idle)) begin
            div_q     <= div_sh;
            per_q     <= per_sh;
            duty_q    <= duty_sh;
            pending_q <= 1'b0;
        end
    end

endmodule
